alu_share_arbiter: RTL and testbench

- Shares one IALU instance between NREQ requesters, e.g. the execute stage and the branch/address-generation path.
- Each requester presents operands and an op over a valid/ready handshake.
- The arbiter picks one requester per cycle, round-robin, evaluates it through the IALU, and registers the result.
- Result is returned on a single response channel tagged with the requester id.

---
 rtl/alu_share_arbiter_pkg.sv | 18 +
 rtl/alu_share_arbiter_rr_pick.sv | 28 ++
 rtl/alu_share_arbiter.sv | 103 ++++++++++
 tb/tb_alu_share_arbiter.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/alu_share_arbiter_pkg.sv
// IALU op codes and op width shared by the arbiter, the decoder and the bench.
package alu_share_arbiter_pkg;
  localparam int ALU_OP_W = 5;

  typedef logic [ALU_OP_W-1:0] alu_op_t;

  localparam alu_op_t ALU_ADD  = 5'd0;
  localparam alu_op_t ALU_SUB  = 5'd1;
  localparam alu_op_t ALU_AND  = 5'd2;
  localparam alu_op_t ALU_OR   = 5'd3;
  localparam alu_op_t ALU_XOR  = 5'd4;
  localparam alu_op_t ALU_SLL  = 5'd5;
  localparam alu_op_t ALU_SRL  = 5'd6;
  localparam alu_op_t ALU_SRA  = 5'd7;
  localparam alu_op_t ALU_SLT  = 5'd8;
  localparam alu_op_t ALU_SLTU = 5'd9;
  localparam alu_op_t ALU_PASB = 5'd10;
endpackage

// File: rtl/alu_share_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, with wrap.
module rr_pick #(
  parameter int N  = 2,
  parameter int IW = 3
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  input  logic          en,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);
  logic hit;

  // Scan from the farthest offset down so the nearest request wins last.
  always_comb begin
    hit = 1'b0;
    idx = '0;
    gnt = '0;
    for (int k = N-1; k >= 0; k--) begin
      if (en && req[(int'(ptr) + k) % N]) begin
        hit = 1'b1;
        idx = IW'((int'(ptr) + k) % N);
      end
    end
    for (int i = 0; i < N; i++)
      gnt[i] = hit && (idx == IW'(i));
  end
endmodule

// File: rtl/alu_share_arbiter.sv
// One IALU shared round-robin by NREQ requesters, single registered response slot.
// Optional per-requester saturating grant counters under ALU_ARB_STATS_EN.
module alu_share_arbiter
  import alu_share_arbiter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int NREQ  = 2,
  parameter int IDW   = 3,
  parameter int CNTW  = 16
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NREQ-1:0]                    req_valid,
  output logic [NREQ-1:0]                    req_ready,
  input  logic [NREQ-1:0][WIDTH-1:0]         req_a,
  input  logic [NREQ-1:0][WIDTH-1:0]         req_b,
  input  logic [NREQ-1:0][ALU_OP_W-1:0]      req_op,
`ifdef ALU_ARB_STATS_EN
  output logic [NREQ-1:0][CNTW-1:0]          grant_cnt,
`endif
  output logic                               rsp_valid,
  input  logic                               rsp_ready,
  output logic [IDW-1:0]                     rsp_id,
  output logic [WIDTH-1:0]                   rsp_result
);
  localparam int SHW = $clog2(WIDTH);

  if ((1 << IDW) < NREQ || NREQ < 1 || NREQ > 8 || CNTW < 1)
    $error("alu_share_arbiter: bad NREQ/IDW/CNTW");

  typedef struct packed {
    logic [IDW-1:0]   id;
    logic [WIDTH-1:0] result;
  } rsp_t;

  function automatic logic [WIDTH-1:0] ialu(input logic [WIDTH-1:0] a,
                                            input logic [WIDTH-1:0] b,
                                            input alu_op_t          op);
    logic [SHW-1:0] sh;
    sh   = b[SHW-1:0];
    ialu = '0;
    case (op)
      ALU_ADD:  ialu = a + b;
      ALU_SUB:  ialu = a - b;
      ALU_AND:  ialu = a & b;
      ALU_OR:   ialu = a | b;
      ALU_XOR:  ialu = a ^ b;
      ALU_SLL:  ialu = a << sh;
      ALU_SRL:  ialu = a >> sh;
      ALU_SRA:  ialu = $signed(a) >>> sh;
      ALU_SLT:  ialu = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
      ALU_SLTU: ialu = {{(WIDTH-1){1'b0}}, a < b};
      ALU_PASB: ialu = b;
      default:  ialu = '0;
    endcase
  endfunction

  logic [IDW-1:0] ptr;
  logic [IDW-1:0] idx;
  logic [NREQ-1:0] gnt;
  logic           out_free, xfer;
  rsp_t           rsp_q;

  assign out_free  = !rsp_valid || rsp_ready;
  assign req_ready = gnt;
  assign xfer      = |gnt;
  assign rsp_id     = rsp_q.id;
  assign rsp_result = rsp_q.result;

  rr_pick #(.N(NREQ), .IW(IDW)) u_pick (
    .req (req_valid),
    .ptr (ptr),
    .en  (out_free && !rst),
    .gnt (gnt),
    .idx (idx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_q     <= '0;
      ptr       <= '0;
    end else if (xfer) begin
      rsp_valid    <= 1'b1;
      rsp_q.id     <= idx;
      rsp_q.result <= ialu(req_a[idx], req_b[idx], req_op[idx]);
      ptr          <= (idx == IDW'(NREQ-1)) ? '0 : idx + IDW'(1);
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

`ifdef ALU_ARB_STATS_EN
  always_ff @(posedge clk) begin
    for (int i = 0; i < NREQ; i++) begin
      if (rst)
        grant_cnt[i] <= '0;
      else if (gnt[i] && req_valid[i] && grant_cnt[i] != '1)
        grant_cnt[i] <= grant_cnt[i] + CNTW'(1);
    end
  end
`endif
endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed table-driven bench for alu_share_arbiter (NREQ=3, CNTW=2).
module tb_alu_share_arbiter;
  import alu_share_arbiter_pkg::*;

  localparam int W = 32, N = 3, IDW = 3, CW = 2;

  logic                        clk = 1'b0;
  logic                        rst;
  logic [N-1:0]                req_valid, req_ready;
  logic [N-1:0][W-1:0]         req_a, req_b;
  logic [N-1:0][ALU_OP_W-1:0]  req_op;
  logic                        rsp_valid, rsp_ready;
  logic [IDW-1:0]              rsp_id;
  logic [W-1:0]                rsp_result;
`ifdef ALU_ARB_STATS_EN
  logic [N-1:0][CW-1:0]        grant_cnt;
`endif

  always #5 clk = ~clk;

  alu_share_arbiter #(.WIDTH(W), .NREQ(N), .IDW(IDW), .CNTW(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_op     (req_op),
`ifdef ALU_ARB_STATS_EN
    .grant_cnt  (grant_cnt),
`endif
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result)
  );

  typedef struct {
    logic             r;
    logic [2:0]       vld;
    logic             rr;
    logic [2:0][31:0] a, b;
    logic [2:0][4:0]  op;
    logic [2:0]       erdy;
    logic             ev;
    logic [2:0]       eid;
    logic [31:0]      eres;
  } vec_t;

  vec_t tv[$];
  int   pass_cnt = 0;
  int   total    = 0;

  function automatic vec_t vec(logic r, logic [2:0] vld, logic rr,
                               logic [31:0] a0, logic [31:0] b0, logic [4:0] o0,
                               logic [31:0] a1, logic [31:0] b1, logic [4:0] o1,
                               logic [31:0] a2, logic [31:0] b2, logic [4:0] o2,
                               logic [2:0] erdy, logic ev, logic [2:0] eid,
                               logic [31:0] eres);
    vec_t v;
    v.r = r; v.vld = vld; v.rr = rr;
    v.a[0] = a0; v.b[0] = b0; v.op[0] = o0;
    v.a[1] = a1; v.b[1] = b1; v.op[1] = o1;
    v.a[2] = a2; v.b[2] = b2; v.op[2] = o2;
    v.erdy = erdy; v.ev = ev; v.eid = eid; v.eres = eres;
    return v;
  endfunction

  task automatic chk(input string name, input int row, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
  endtask

  task automatic drive(input vec_t v);
    rst       = v.r;
    req_valid = v.vld;
    rsp_ready = v.rr;
    req_a     = v.a;
    req_b     = v.b;
    req_op    = v.op;
  endtask

  initial begin
    // Reset, single request
    tv.push_back(vec(1, 3'b000, 1,  0, 0, ALU_ADD,  0, 0, ALU_ADD,  0, 0, ALU_ADD,  3'b000, 0, 0, 0));
    tv.push_back(vec(0, 3'b001, 1,  7, 5, ALU_ADD,  0, 0, ALU_ADD,  0, 0, ALU_ADD,  3'b001, 1, 0, 12));
    tv.push_back(vec(0, 3'b000, 1,  7, 5, ALU_ADD,  0, 0, ALU_ADD,  0, 0, ALU_ADD,  3'b000, 0, 0, 12));
    // Contention alternates 0,1,0,1 from a fresh pointer
    tv.push_back(vec(1, 3'b000, 1,  0, 0, ALU_ADD,  0, 0, ALU_ADD,  0, 0, ALU_ADD,  3'b000, 0, 0, 0));
    tv.push_back(vec(0, 3'b011, 1,  1, 1, ALU_ADD, 10, 3, ALU_SUB,  0, 0, ALU_ADD,  3'b001, 1, 0, 2));
    tv.push_back(vec(0, 3'b011, 1,  1, 1, ALU_ADD, 10, 3, ALU_SUB,  0, 0, ALU_ADD,  3'b010, 1, 1, 7));
    tv.push_back(vec(0, 3'b011, 1,  1, 1, ALU_ADD, 10, 3, ALU_SUB,  0, 0, ALU_ADD,  3'b001, 1, 0, 2));
    tv.push_back(vec(0, 3'b011, 1,  1, 1, ALU_ADD, 10, 3, ALU_SUB,  0, 0, ALU_ADD,  3'b010, 1, 1, 7));
    // Backpressure for 3 cycles with req1 waiting, then release
    for (int k = 0; k < 3; k++)
      tv.push_back(vec(0, 3'b010, 0, 1, 1, ALU_ADD, 20, 4, ALU_SUB,  0, 0, ALU_ADD,  3'b000, 1, 1, 7));
    tv.push_back(vec(0, 3'b010, 1,  1, 1, ALU_ADD, 20, 4, ALU_SUB,  0, 0, ALU_ADD,  3'b010, 1, 1, 16));
    tv.push_back(vec(0, 3'b000, 1,  1, 1, ALU_ADD, 20, 4, ALU_SUB,  0, 0, ALU_ADD,  3'b000, 0, 1, 16));
    // Pointer wrap: req2 alone, then req0 beats req2
    tv.push_back(vec(0, 3'b100, 1,  0, 0, ALU_ADD,  0, 0, ALU_ADD, 100, 1, ALU_ADD, 3'b100, 1, 2, 101));
    tv.push_back(vec(0, 3'b101, 1,  3, 4, ALU_XOR,  0, 0, ALU_ADD, 100, 1, ALU_ADD, 3'b001, 1, 0, 7));
    tv.push_back(vec(0, 3'b100, 1,  3, 4, ALU_XOR,  0, 0, ALU_ADD, 100, 1, ALU_ADD, 3'b100, 1, 2, 101));
    // Reset with a pending response; pointer was 1 and must return to 0
    tv.push_back(vec(0, 3'b001, 1,  3, 4, ALU_XOR, 20, 4, ALU_SUB, 100, 1, ALU_ADD, 3'b001, 1, 0, 7));
    tv.push_back(vec(0, 3'b011, 0,  3, 4, ALU_XOR, 20, 4, ALU_SUB, 100, 1, ALU_ADD, 3'b000, 1, 0, 7));
    tv.push_back(vec(1, 3'b011, 0,  3, 4, ALU_XOR, 20, 4, ALU_SUB, 100, 1, ALU_ADD, 3'b000, 0, 0, 0));
    tv.push_back(vec(0, 3'b011, 1,  3, 4, ALU_XOR, 20, 4, ALU_SUB, 100, 1, ALU_ADD, 3'b001, 1, 0, 7));
    tv.push_back(vec(0, 3'b111, 1,  3, 4, ALU_XOR, 20, 4, ALU_SUB, 100, 1, ALU_ADD, 3'b010, 1, 1, 16));
    tv.push_back(vec(0, 3'b111, 1,  3, 4, ALU_XOR, 20, 4, ALU_SUB, 100, 1, ALU_ADD, 3'b100, 1, 2, 101));
    tv.push_back(vec(0, 3'b000, 0,  0, 0, ALU_ADD,  0, 0, ALU_ADD,  0, 0, ALU_ADD,  3'b000, 1, 2, 101));
    tv.push_back(vec(0, 3'b000, 1,  0, 0, ALU_ADD,  0, 0, ALU_ADD,  0, 0, ALU_ADD,  3'b000, 0, 2, 101));
    // Other IALU ops
    tv.push_back(vec(0, 3'b001, 1, 32'hFFFF_FFFF, 1, ALU_SLT, 0, 0, ALU_ADD, 0, 0, ALU_ADD, 3'b001, 1, 0, 1));
    tv.push_back(vec(0, 3'b010, 1,  0, 0, ALU_ADD, 32'h8000_0000, 4, ALU_SRA, 0, 0, ALU_ADD, 3'b010, 1, 1, 32'hF800_0000));
    tv.push_back(vec(0, 3'b100, 1,  0, 0, ALU_ADD,  0, 0, ALU_ADD,  5, 9, ALU_SUB,  3'b100, 1, 2, 32'hFFFF_FFFC));
    tv.push_back(vec(0, 3'b001, 1, 32'hFFFF_FFFF, 1, ALU_SLTU, 0, 0, ALU_ADD, 0, 0, ALU_ADD, 3'b001, 1, 0, 0));
    tv.push_back(vec(0, 3'b010, 1,  0, 0, ALU_ADD,  3, 4, ALU_SLL,  0, 0, ALU_ADD,  3'b010, 1, 1, 48));
    tv.push_back(vec(0, 3'b000, 1,  0, 0, ALU_ADD,  0, 0, ALU_ADD,  0, 0, ALU_ADD,  3'b000, 0, 1, 48));

    foreach (tv[i]) begin
      drive(tv[i]);
      #3;
      chk("req_ready", i, 32'(req_ready), 32'(tv[i].erdy));
      @(posedge clk); #1;
      chk("rsp_valid", i, 32'(rsp_valid), 32'(tv[i].ev));
      chk("rsp_id", i, 32'(rsp_id), 32'(tv[i].eid));
      chk("rsp_result", i, rsp_result, tv[i].eres);
    end

    // Throughput: two requesters held valid, one response per cycle, ids alternate
    drive(vec(1, 3'b000, 1, 0, 0, ALU_ADD, 0, 0, ALU_ADD, 0, 0, ALU_ADD, 0, 0, 0, 0));
    @(posedge clk); #1;
    drive(vec(0, 3'b011, 1, 1, 1, ALU_ADD, 10, 3, ALU_SUB, 0, 0, ALU_ADD, 0, 0, 0, 0));
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      chk("tput_valid", 100 + k, 32'(rsp_valid), 32'd1);
      chk("tput_id", 100 + k, 32'(rsp_id), 32'(k % 2));
    end

`ifdef ALU_ARB_STATS_EN
    // Counter saturation at 3 after five grants, then cleared by reset
    drive(vec(1, 3'b000, 1, 0, 0, ALU_ADD, 0, 0, ALU_ADD, 0, 0, ALU_ADD, 0, 0, 0, 0));
    @(posedge clk); #1;
    drive(vec(0, 3'b001, 1, 1, 1, ALU_ADD, 0, 0, ALU_ADD, 0, 0, ALU_ADD, 0, 0, 0, 0));
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
    end
    req_valid = '0;
    @(posedge clk); #1;
    chk("cnt0_sat", 200, 32'(grant_cnt[0]), 32'd3);
    chk("cnt1", 200, 32'(grant_cnt[1]), 32'd0);
    chk("cnt2", 200, 32'(grant_cnt[2]), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("cnt0_rst", 201, 32'(grant_cnt[0]), 32'd0);
    chk("cnt1_rst", 201, 32'(grant_cnt[1]), 32'd0);
`endif

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
